// File: rtl/mem_io_bridge_pkg.sv
// Shared address map for the CPU memory bridge: I/O window base and register offsets.
// Pure constants, no logic, no latency.
package mem_io_bridge_pkg;

    localparam logic [9:0] IO_BASE_DEF   = 10'h3F0;

    localparam logic [3:0] OFF_BTN_STATE = 4'd0;
    localparam logic [3:0] OFF_BTN_EDGE  = 4'd1;
    localparam logic [3:0] OFF_LED       = 4'd2;
    localparam logic [3:0] OFF_TICK      = 4'd3;

endpackage

// File: rtl/mem_io_bridge_btn_debounce.sv
// One button bit: 2-flop synchronizer, then a counter that accepts a change after DEBOUNCE_CYCLES stable samples.
// Latency 2 + DEBOUNCE_CYCLES clocks from a clean input change to stable; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic stable,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          cnt_done;

    assign cnt_done = (cnt == CW'(DEBOUNCE_CYCLES - 1));
    // Pulses in the cycle before stable goes 0->1, so the edge flag sets on the same clock.
    assign rise     = sync2 & ~stable & cnt_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt_done) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// Decodes CPU accesses to block RAM or the I/O window (buttons, edges, LEDs, tick counter).
// Read data 1 cycle after address for both paths; no backpressure, every access completes.
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int                 ADDR_W          = 10,
    parameter int                 DATA_W          = 16,
    parameter int                 NUM_BTN         = 8,
    parameter logic [ADDR_W-1:0]  IO_BASE         = IO_BASE_DEF,
    parameter int                 DEBOUNCE_CYCLES = 16,
    parameter int                 TICK_DIV        = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [NUM_BTN-1:0] buttons,
    output logic [DATA_W-1:0] leds
);

    localparam int TW = $clog2(TICK_DIV);

    logic               io_hit;
    logic [3:0]         offset;
    logic               io_wr;
    logic               edge_clr;
    logic               tick_clr;
    logic               tick_tc;
    logic [DATA_W-1:0]  io_val;
    logic [DATA_W-1:0]  io_q;
    logic               io_hit_q;
    logic               rd_vld;
    logic [NUM_BTN-1:0] btn_state;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] btn_edge;
    logic [TW-1:0]      presc;
    logic [DATA_W-1:0]  tick;

    assign io_hit    = (cpu_addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    assign offset    = cpu_addr[3:0];
    assign ram_addr  = cpu_addr;
    assign ram_wdata = cpu_wdata;
    assign ram_we    = cpu_we & ~io_hit;

    assign io_wr     = cpu_we & io_hit;
    assign edge_clr  = io_hit & ~cpu_we & (offset == OFF_BTN_EDGE);
    assign tick_clr  = io_wr & (offset == OFF_TICK);
    assign tick_tc   = (presc == TW'(TICK_DIV - 1));

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .btn    (buttons[gi]),
            .stable (btn_state[gi]),
            .rise   (btn_rise[gi])
        );
    end

    always_comb begin
        io_val = '0;
        case (offset)
            OFF_BTN_STATE: io_val = DATA_W'(btn_state);
            OFF_BTN_EDGE:  io_val = DATA_W'(btn_edge);
            OFF_LED:       io_val = leds;
            OFF_TICK:      io_val = tick;
            default:       io_val = '0;
        endcase
    end

    // rd_vld holds the output at zero until the first post-reset capture, matching an idle RAM.
    assign cpu_rdata = !rd_vld ? '0 : (io_hit_q ? io_q : ram_rdata);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld   <= 1'b0;
            io_hit_q <= 1'b0;
            io_q     <= '0;
            btn_edge <= '0;
            leds     <= '0;
            presc    <= '0;
            tick     <= '0;
        end else begin
            rd_vld   <= 1'b1;
            io_hit_q <= io_hit;
            io_q     <= cpu_we ? cpu_wdata : io_val;
            // A rise in the clearing cycle survives: set wins over clear-on-read.
            btn_edge <= (btn_edge & ~{NUM_BTN{edge_clr}}) | btn_rise;
            if (io_wr && (offset == OFF_LED)) begin
                leds <= cpu_wdata;
            end
            if (tick_clr) begin
                presc <= '0;
                tick  <= '0;
            end else if (tick_tc) begin
                presc <= '0;
                tick  <= tick + DATA_W'(1);
            end else begin
                presc <= presc + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: RAM model, vector table, and hand sequences for debounce, edge race, tick and reset.
module tb_mem_io_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic [15:0] cpu_rdata;
    logic [9:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [7:0]  buttons;
    logic [15:0] leds;

    int n_chk = 0;
    int n_err = 0;

    mem_io_bridge #(
        .ADDR_W          (10),
        .DATA_W          (16),
        .NUM_BTN         (8),
        .IO_BASE         (10'h3F0),
        .DEBOUNCE_CYCLES (16),
        .TICK_DIV        (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .buttons   (buttons),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    // Write-first block RAM with registered read.
    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            ram_rdata     <= ram_wdata;
        end else begin
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic        chk;
        logic [15:0] exp;
        string       name;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic        we;
        logic        exp_we;
        logic        chk;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one access at the falling edge; the access driven one cycle earlier is scored first.
    task automatic step(input logic [9:0] a, input logic [15:0] d, input logic we,
                        input logic chk, input logic [15:0] e, input string nm);
        sb_t t;
        @(negedge clk);
        if (sb.size() > 0) begin
            t = sb.pop_front();
            if (t.chk) check(t.name, cpu_rdata, t.exp);
        end
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = we;
        t.chk  = chk;
        t.exp  = e;
        t.name = nm;
        sb.push_back(t);
    endtask

    task automatic idle();
        step(10'h000, 16'h0000, 1'b0, 1'b0, 16'h0000, "idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{10'h010, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h1234, "ram_store"};
        vecs[1]  = '{10'h010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, "ram_load"};
        vecs[2]  = '{10'h3F2, 16'h00A5, 1'b1, 1'b0, 1'b1, 16'h00A5, "led_store"};
        vecs[3]  = '{10'h3F2, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00A5, "led_load"};
        vecs[4]  = '{10'h3F0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, "btn_idle"};
        vecs[5]  = '{10'h3F5, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'hBEEF, "rsvd_store"};
        vecs[6]  = '{10'h3F5, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, "rsvd_load"};
        vecs[7]  = '{10'h3F2, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00A5, "led_unchanged"};
        vecs[8]  = '{10'h011, 16'h5A5A, 1'b1, 1'b1, 1'b1, 16'h5A5A, "ram_store2"};
        vecs[9]  = '{10'h3EF, 16'h7777, 1'b1, 1'b1, 1'b1, 16'h7777, "below_win_store"};
        vecs[10] = '{10'h010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, "ram_reload"};
        vecs[11] = '{10'h3EF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h7777, "below_win_load"};
        vecs[12] = '{10'h3FF, 16'h1111, 1'b1, 1'b0, 1'b1, 16'h1111, "top_win_store"};
        vecs[13] = '{10'h3FF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, "top_win_load"};

        reset     = 1'b0;
        buttons   = 8'h00;
        cpu_addr  = 10'h020;
        cpu_wdata = 16'h0000;
        cpu_we    = 1'b1;
        #12;
        check("rst_rdata", cpu_rdata, 16'h0000);
        check("rst_leds", leds, 16'h0000);
        check("rst_ram_we_ungated", {15'b0, ram_we}, 16'h0001);
        @(negedge clk);
        cpu_we = 1'b0;
        reset  = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].chk, vecs[i].exp, vecs[i].name);
            #1;
            check({vecs[i].name, "_ram_we"}, {15'b0, ram_we}, {15'b0, vecs[i].exp_we});
        end
        check("leds_port", leds, 16'h00A5);

        // Bouncing press on button 0; last toggle (to 1) lands on c=18.
        for (int c = 0; c < 19; c++) begin
            step(10'h3F0, 16'h0000, 1'b0, 1'b1, 16'h0000, "btn_bounce");
            if (c % 3 == 0) buttons[0] = ~buttons[0];
        end
        for (int j = 1; j <= 20; j++) begin
            step(10'h3F0, 16'h0000, 1'b0, 1'b1, (j >= 18) ? 16'h0001 : 16'h0000, "btn_state_rise");
        end
        step(10'h3F1, 16'h0000, 1'b0, 1'b1, 16'h0001, "edge_first");
        step(10'h3F1, 16'h0000, 1'b0, 1'b1, 16'h0000, "edge_cleared");

        // Button 1 debounces so its rise coincides with the clearing read of BTN_EDGE.
        buttons[1] = 1'b1;
        for (int k = 0; k < 16; k++) idle();
        step(10'h3F1, 16'h0000, 1'b0, 1'b1, 16'h0000, "edge_race_old");
        step(10'h3F1, 16'h0000, 1'b0, 1'b1, 16'h0002, "edge_race_kept");
        step(10'h3F1, 16'h0000, 1'b0, 1'b1, 16'h0000, "edge_race_cleared");

        // Tick counter with TICK_DIV=4.
        step(10'h3F3, 16'h1357, 1'b1, 1'b1, 16'h1357, "tick_wr");
        for (int k = 0; k < 40; k++) idle();
        step(10'h3F3, 16'h0000, 1'b0, 1'b1, 16'd10, "tick_40");
        idle();
        idle();
        step(10'h3F3, 16'hABCD, 1'b1, 1'b1, 16'hABCD, "tick_wr_tc");
        step(10'h3F3, 16'h0000, 1'b0, 1'b1, 16'h0000, "tick_tc_clear");
        idle();
        force dut.tick = 16'hFFFF;
        step(10'h3F3, 16'h0000, 1'b0, 1'b1, 16'hFFFF, "tick_forced");
        release dut.tick;
        idle();
        step(10'h3F3, 16'h0000, 1'b0, 1'b1, 16'h0000, "tick_wrap");
        idle();

        // Release, then press all buttons so BTN_EDGE becomes 8'hFF.
        buttons = 8'h00;
        for (int k = 0; k < 20; k++) idle();
        buttons = 8'hFF;
        for (int k = 0; k < 20; k++) idle();
        check("leds_hold", leds, 16'h00A5);

        step(10'h3F1, 16'h0000, 1'b0, 1'b0, 16'h0000, "edge_all");
        @(posedge clk);
        #2;
        check("edge_all_capture", cpu_rdata, 16'h00FF);
        reset = 1'b0;
        #1;
        check("rst_mid_rdata", cpu_rdata, 16'h0000);
        check("rst_mid_leds", leds, 16'h0000);
        sb.delete();
        @(negedge clk);
        check("rst_hold_rdata", cpu_rdata, 16'h0000);
        reset = 1'b1;

        step(10'h3F1, 16'h0000, 1'b0, 1'b1, 16'h0000, "post_rst_edge");
        step(10'h3F3, 16'h0000, 1'b0, 1'b1, 16'h0000, "post_rst_tick");
        step(10'h3F2, 16'h0000, 1'b0, 1'b1, 16'h0000, "post_rst_led");
        step(10'h3F0, 16'h0000, 1'b0, 1'b1, 16'h0000, "post_rst_state");
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
